// File: rtl/sound_ac97_serializer_pkg.sv
// Shared sound constants: AC97 frame geometry, tag bits, sample limits and the command-slot FSM type.
package sound_ac97_serializer_pkg;

  localparam int unsigned Ac97FrameBits = 256;
  localparam int unsigned Ac97SyncBits  = 16;
  localparam int unsigned Ac97SlotBits  = 20;

  localparam int unsigned TagPos   = 0;
  localparam int unsigned Slot1Pos = 16;
  localparam int unsigned Slot2Pos = 36;
  localparam int unsigned Slot3Pos = 56;
  localparam int unsigned Slot4Pos = 76;

  localparam int unsigned TagValidBit = 15;
  localparam int unsigned TagSlot1Bit = 14;
  localparam int unsigned TagSlot2Bit = 13;
  localparam int unsigned TagSlot3Bit = 12;
  localparam int unsigned TagSlot4Bit = 11;

  typedef logic [Ac97SlotBits-1:0] sample_t;

  localparam sample_t SatMax = 20'h7FFFF;
  localparam sample_t SatMin = 20'h80000;

  typedef enum logic [0:0] {StCmdEmpty, StCmdFull} cmd_state_e;

  // Frame is always valid with both PCM slots; command slots are flagged only when populated.
  function automatic logic [15:0] ac97_tag(input logic with_cmd);
    logic [15:0] t;
    t              = '0;
    t[TagValidBit] = 1'b1;
    t[TagSlot3Bit] = 1'b1;
    t[TagSlot4Bit] = 1'b1;
    t[TagSlot1Bit] = with_cmd;
    t[TagSlot2Bit] = with_cmd;
    return t;
  endfunction

endpackage

// File: rtl/sound_ac97_serializer_if.sv
// Channel/mix inputs, codec command handshake and AC97 serial outputs of the sound serializer.
interface sound_ac97_serializer_if;
  import sound_ac97_serializer_pkg::*;

  sample_t     I_CH1_WAVEFORM;
  sample_t     I_CH2_WAVEFORM;
  sample_t     I_CH3_WAVEFORM;
  sample_t     I_CH4_WAVEFORM;
  logic [7:0]  I_NR50_DATA;
  logic [7:0]  I_NR51_DATA;
  logic        I_SOUND_EN;
  logic        I_CMD_VALID;
  logic [6:0]  I_CMD_ADDR;
  logic [15:0] I_CMD_DATA;
  logic        O_CMD_READY;
  logic        O_STROBE;
  logic        O_SYNC;
  logic        O_SDATA_OUT;

  modport master (
    output I_CH1_WAVEFORM, I_CH2_WAVEFORM, I_CH3_WAVEFORM, I_CH4_WAVEFORM,
    output I_NR50_DATA, I_NR51_DATA, I_SOUND_EN, I_CMD_VALID, I_CMD_ADDR, I_CMD_DATA,
    input  O_CMD_READY, O_STROBE, O_SYNC, O_SDATA_OUT
  );

  modport slave (
    input  I_CH1_WAVEFORM, I_CH2_WAVEFORM, I_CH3_WAVEFORM, I_CH4_WAVEFORM,
    input  I_NR50_DATA, I_NR51_DATA, I_SOUND_EN, I_CMD_VALID, I_CMD_ADDR, I_CMD_DATA,
    output O_CMD_READY, O_STROBE, O_SYNC, O_SDATA_OUT
  );

endinterface

// File: rtl/sound_side_mixer.sv
// One output side: sums the selected channels, applies (vol+1)/8 gain and saturates to 20 bits.
module sound_side_mixer
  import sound_ac97_serializer_pkg::*;
(
  input  sample_t    ch1_i,
  input  sample_t    ch2_i,
  input  sample_t    ch3_i,
  input  sample_t    ch4_i,
  input  logic [3:0] sel_i,
  input  logic [2:0] vol_i,
  output sample_t    sample_o
);

  sample_t            ch [4];
  logic signed [21:0] sum;
  logic signed [25:0] sum_ext;
  logic signed [25:0] gain;
  logic signed [25:0] prod;
  logic        [22:0] scaled;
  logic               fits;
  logic               unused_prod_lsb;

  assign ch[0] = ch1_i;
  assign ch[1] = ch2_i;
  assign ch[2] = ch3_i;
  assign ch[3] = ch4_i;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel_i[i]) sum = sum + $signed({{2{ch[i][19]}}, ch[i]});
    end
  end

  assign sum_ext = {{4{sum[21]}}, sum};
  assign gain    = {22'd0, {1'b0, vol_i} + 4'd1};
  assign prod    = sum_ext * gain;

  // Arithmetic >>> 3 done by dropping the three LSBs of the sign-extended product.
  assign scaled          = prod[25:3];
  assign unused_prod_lsb = ^prod[2:0];

  assign fits     = (&scaled[22:19]) | (~|scaled[22:19]);
  assign sample_o = fits ? scaled[19:0] : (scaled[22] ? SatMin : SatMax);

endmodule

// File: rtl/sound_ac97_serializer.sv
// Mixes four channels into AC97 PCM slots and serializes 256-bit frames on the codec bit clock.
// Command slots 1/2 and the codec-register handshake exist only with SOUND_AC97_CMD_SLOT_EN.
module sound_ac97_serializer
  import sound_ac97_serializer_pkg::*;
#(
  parameter int unsigned FRAME_BITS = Ac97FrameBits,
  parameter int unsigned STROBE_POS = 128
) (
  input logic                    I_BITCLK,
  input logic                    I_RESET,
  sound_ac97_serializer_if.slave bus
);

  localparam int unsigned    CntW    = $clog2(FRAME_BITS);
  localparam int unsigned    PadBits = FRAME_BITS - Slot4Pos - Ac97SlotBits;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_BITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, frame_new;
  logic                  sdata_q, sdata_d, sync_q, sync_d, strobe_q, strobe_d;
  logic                  snap;
  logic                  cmd_in_frame;
  sample_t               mix_left, mix_right, slot1, slot2, slot3, slot4;
  logic                  unused_nr50;

  assign snap        = (cnt_q == CntLast);
  assign unused_nr50 = ^{bus.I_NR50_DATA[7], bus.I_NR50_DATA[3]};

  sound_side_mixer u_mix_left (
    .ch1_i    (bus.I_CH1_WAVEFORM),
    .ch2_i    (bus.I_CH2_WAVEFORM),
    .ch3_i    (bus.I_CH3_WAVEFORM),
    .ch4_i    (bus.I_CH4_WAVEFORM),
    .sel_i    (bus.I_NR51_DATA[7:4]),
    .vol_i    (bus.I_NR50_DATA[6:4]),
    .sample_o (mix_left)
  );

  sound_side_mixer u_mix_right (
    .ch1_i    (bus.I_CH1_WAVEFORM),
    .ch2_i    (bus.I_CH2_WAVEFORM),
    .ch3_i    (bus.I_CH3_WAVEFORM),
    .ch4_i    (bus.I_CH4_WAVEFORM),
    .sel_i    (bus.I_NR51_DATA[3:0]),
    .vol_i    (bus.I_NR50_DATA[2:0]),
    .sample_o (mix_right)
  );

`ifdef SOUND_AC97_CMD_SLOT_EN
  cmd_state_e  cmd_state_q, cmd_state_d;
  logic [6:0]  cmd_addr_q;
  logic [15:0] cmd_data_q;
  logic        cmd_accept;

  always_ff @(posedge I_BITCLK or posedge I_RESET) begin
    if (I_RESET) begin
      cmd_state_q <= StCmdEmpty;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
    end else begin
      cmd_state_q <= cmd_state_d;
      if (cmd_accept) begin
        cmd_addr_q <= bus.I_CMD_ADDR;
        cmd_data_q <= bus.I_CMD_DATA;
      end
    end
  end

  // A command accepted on the snapshot edge misses that frame and waits for the next one.
  always_comb begin
    cmd_state_d = cmd_state_q;
    unique case (cmd_state_q)
      StCmdEmpty: if (bus.I_CMD_VALID) cmd_state_d = StCmdFull;
      StCmdFull:  if (snap)            cmd_state_d = StCmdEmpty;
      default:                         cmd_state_d = StCmdEmpty;
    endcase
  end

  always_comb begin
    bus.O_CMD_READY = (cmd_state_q == StCmdEmpty);
    cmd_in_frame    = (cmd_state_q == StCmdFull);
    cmd_accept      = bus.I_CMD_VALID && (cmd_state_q == StCmdEmpty);
  end

  assign slot1 = cmd_in_frame ? {1'b0, cmd_addr_q, 12'h000} : '0;
  assign slot2 = cmd_in_frame ? {cmd_data_q, 4'h0} : '0;
`else
  logic unused_cmd;

  assign unused_cmd      = ^{bus.I_CMD_VALID, bus.I_CMD_ADDR, bus.I_CMD_DATA};
  assign bus.O_CMD_READY = 1'b0;
  assign cmd_in_frame    = 1'b0;
  assign slot1           = '0;
  assign slot2           = '0;
`endif

  assign slot3     = bus.I_SOUND_EN ? mix_left  : '0;
  assign slot4     = bus.I_SOUND_EN ? mix_right : '0;
  assign frame_new = {ac97_tag(cmd_in_frame), slot1, slot2, slot3, slot4, {PadBits{1'b0}}};

  // The frame is loaded into a shift register so bit k leaves on the edge that sets cnt to k.
  always_comb begin
    cnt_d = snap ? '0 : cnt_q + CntW'(1);
    if (snap) begin
      sdata_d = frame_new[FRAME_BITS-1];
      shift_d = {frame_new[FRAME_BITS-2:0], 1'b0};
    end else begin
      sdata_d = shift_q[FRAME_BITS-1];
      shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
    end
    sync_d   = (cnt_d == CntLast) || (cnt_d < CntW'(Ac97SyncBits - 1));
    strobe_d = (cnt_d == CntW'(STROBE_POS));
  end

  always_ff @(posedge I_BITCLK or posedge I_RESET) begin
    if (I_RESET) begin
      cnt_q    <= CntLast;
      shift_q  <= '0;
      sdata_q  <= 1'b0;
      sync_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      sdata_q  <= sdata_d;
      sync_q   <= sync_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.O_SDATA_OUT = sdata_q;
  assign bus.O_SYNC      = sync_q;
  assign bus.O_STROBE    = strobe_q;

endmodule

// File: tb/tb_sound_ac97_serializer.sv
// Directed bench for sound_ac97_serializer: frame timing, mixing, saturation, command slots, reset.
module tb_sound_ac97_serializer;

`ifdef SOUND_AC97_CMD_SLOT_EN
  localparam logic ReadyIdle = 1'b1;
`else
  localparam logic ReadyIdle = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] k_tb;
  int         n_total = 0;
  int         n_bad   = 0;

  sound_ac97_serializer_if bus ();

  sound_ac97_serializer u_dut (
    .I_BITCLK (clk),
    .I_RESET  (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side frame position: first edge after reset release is position 0.
  always @(posedge clk or posedge rst) begin
    if (rst) k_tb <= 8'd255;
    else     k_tb <= k_tb + 8'd1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_k(input logic [7:0] k);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (k_tb != k && g < 600);
    if (k_tb != k) check_val("wait_k_timeout", 32'(k_tb), 32'(k));
  endtask

  // Collects the next whole frame; f[255-k] holds the bit seen at position k.
  task automatic grab_frame(output logic [255:0] f, output logic rdy0);
    int g;
    g = 0;
    while (k_tb != 8'd255 && g < 600) begin
      @(negedge clk);
      g++;
    end
    if (k_tb != 8'd255) check_val("frame_align_timeout", 32'(k_tb), 32'd255);
    rdy0 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      f[255-i] = bus.O_SDATA_OUT;
      if (i == 0) rdy0 = bus.O_CMD_READY;
    end
  endtask

  task automatic check_frame(input string name, input logic [255:0] f, input logic [15:0] tag,
                             input logic [19:0] s1, input logic [19:0] s2,
                             input logic [19:0] s3, input logic [19:0] s4);
    check_val({name, "_tag"},   32'(f[255:240]), 32'(tag));
    check_val({name, "_slot1"}, 32'(f[239:220]), 32'(s1));
    check_val({name, "_slot2"}, 32'(f[219:200]), 32'(s2));
    check_val({name, "_slot3"}, 32'(f[199:180]), 32'(s3));
    check_val({name, "_slot4"}, 32'(f[179:160]), 32'(s4));
    check_val({name, "_pad"},   32'(|f[159:0]),  32'd0);
  endtask

  task automatic set_mix(input logic [19:0] c1, input logic [19:0] c2, input logic [19:0] c3,
                         input logic [19:0] c4, input logic [7:0] nr50, input logic [7:0] nr51,
                         input logic en);
    bus.I_CH1_WAVEFORM = c1;
    bus.I_CH2_WAVEFORM = c2;
    bus.I_CH3_WAVEFORM = c3;
    bus.I_CH4_WAVEFORM = c4;
    bus.I_NR50_DATA    = nr50;
    bus.I_NR51_DATA    = nr51;
    bus.I_SOUND_EN     = en;
  endtask

  task automatic pulse_cmd(input logic [6:0] addr, input logic [15:0] data);
    bus.I_CMD_ADDR  = addr;
    bus.I_CMD_DATA  = data;
    bus.I_CMD_VALID = 1'b1;
    @(negedge clk);
    bus.I_CMD_VALID = 1'b0;
  endtask

  initial begin
    logic [255:0] f;
    logic         r0;
    int           sync_hi, strobe_hi, sync_err, strobe_err;

    rst             = 1'b0;
    bus.I_CMD_VALID = 1'b0;
    bus.I_CMD_ADDR  = '0;
    bus.I_CMD_DATA  = '0;
    set_mix(20'h0, 20'h0, 20'h0, 20'h0, 8'h00, 8'h00, 1'b0);
    #1 rst = 1'b1;

    repeat (3) @(negedge clk);
    check_val("rst_sync",   32'(bus.O_SYNC),      32'd0);
    check_val("rst_sdata",  32'(bus.O_SDATA_OUT), 32'd0);
    check_val("rst_strobe", 32'(bus.O_STROBE),    32'd0);
    check_val("rst_ready",  32'(bus.O_CMD_READY), 32'(ReadyIdle));
    rst = 1'b0;

    // SYNC / strobe timing over 600 cycles
    sync_hi = 0; strobe_hi = 0; sync_err = 0; strobe_err = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 0) check_val("sync_first_rise", 32'(bus.O_SYNC), 32'd1);
      sync_hi   += int'(bus.O_SYNC);
      strobe_hi += int'(bus.O_STROBE);
      if (bus.O_SYNC !== ((k_tb == 8'd255) || (k_tb < 8'd15))) sync_err++;
      if (bus.O_STROBE !== (k_tb == 8'd128)) strobe_err++;
    end
    check_val("sync_count",   32'(sync_hi),    32'd47);
    check_val("strobe_count", 32'(strobe_hi),  32'd2);
    check_val("sync_pos",     32'(sync_err),   32'd0);
    check_val("strobe_pos",   32'(strobe_err), 32'd0);

    set_mix(20'h01000, 20'h0, 20'h0, 20'h0, 8'h77, 8'h11, 1'b1);
    grab_frame(f, r0);
    check_frame("unity", f, 16'h9800, 20'h0, 20'h0, 20'h01000, 20'h01000);

    set_mix(20'h00800, 20'h0, 20'h0, 20'h0, 8'h30, 8'h10, 1'b1);
    grab_frame(f, r0);
    check_frame("volpan", f, 16'h9800, 20'h0, 20'h0, 20'h00400, 20'h0);

    set_mix(20'h00800, 20'h0, 20'h0, 20'h0, 8'h30, 8'h10, 1'b0);
    grab_frame(f, r0);
    check_frame("disabled", f, 16'h9800, 20'h0, 20'h0, 20'h0, 20'h0);

    set_mix(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 8'h77, 8'hFF, 1'b1);
    grab_frame(f, r0);
    check_frame("sat_pos", f, 16'h9800, 20'h0, 20'h0, 20'h7FFFF, 20'h7FFFF);

    set_mix(20'h80000, 20'h80000, 20'h80000, 20'h80000, 8'h77, 8'hFF, 1'b1);
    grab_frame(f, r0);
    check_frame("sat_neg", f, 16'h9800, 20'h0, 20'h0, 20'h80000, 20'h80000);

    set_mix(20'h01000, 20'h0, 20'h0, 20'h0, 8'h77, 8'h11, 1'b1);
    wait_k(8'd100);
    pulse_cmd(7'h02, 16'h0808);
    check_val("cmd_ready_busy", 32'(bus.O_CMD_READY), 32'd0);
    wait_k(8'd255);
    check_val("cmd_ready_held", 32'(bus.O_CMD_READY), 32'd0);
    grab_frame(f, r0);
    check_val("cmd_ready_back", 32'(r0), 32'(ReadyIdle));
`ifdef SOUND_AC97_CMD_SLOT_EN
    check_frame("cmd", f, 16'hF800, 20'h02000, 20'h08080, 20'h01000, 20'h01000);

    // Command presented on the snapshot edge lands one frame later.
    bus.I_CMD_ADDR  = 7'h7F;
    bus.I_CMD_DATA  = 16'hABCD;
    bus.I_CMD_VALID = 1'b1;
    fork
      begin
        @(posedge clk);
        #1 bus.I_CMD_VALID = 1'b0;
      end
    join_none
    grab_frame(f, r0);
    check_val("edge_cmd_ready", 32'(r0), 32'd0);
    check_frame("edge_cmd_skip", f, 16'h9800, 20'h0, 20'h0, 20'h01000, 20'h01000);
    grab_frame(f, r0);
    check_val("edge_cmd_ready_back", 32'(r0), 32'd1);
    check_frame("edge_cmd", f, 16'hF800, 20'h7F000, 20'hABCD0, 20'h01000, 20'h01000);
`else
    check_frame("cmd_ignored", f, 16'h9800, 20'h0, 20'h0, 20'h01000, 20'h01000);
`endif

    // Reset mid-frame with a command pending
    wait_k(8'd50);
    pulse_cmd(7'h11, 16'h1234);
    wait_k(8'd100);
    check_val("rst_mid_pending", 32'(bus.O_CMD_READY), 32'd0);
    rst = 1'b1;
    #1;
    check_val("rst_mid_ready",  32'(bus.O_CMD_READY), 32'(ReadyIdle));
    check_val("rst_mid_sync",   32'(bus.O_SYNC),      32'd0);
    check_val("rst_mid_sdata",  32'(bus.O_SDATA_OUT), 32'd0);
    check_val("rst_mid_strobe", 32'(bus.O_STROBE),    32'd0);
    repeat (2) @(negedge clk);
    check_val("rst_hold_sync", 32'(bus.O_SYNC), 32'd0);
    rst = 1'b0;
    grab_frame(f, r0);
    check_val("rst_after_ready", 32'(r0), 32'(ReadyIdle));
    check_frame("rst_after", f, 16'h9800, 20'h0, 20'h0, 20'h01000, 20'h01000);

    // Asynchronous reset while SYNC is high
    wait_k(8'd3);
    check_val("sync_hi_pre", 32'(bus.O_SYNC), 32'd1);
    rst = 1'b1;
    #1;
    check_val("sync_async_clear", 32'(bus.O_SYNC), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
